// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for the multi-cycle ALU.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_MUL = 4'd2,
      OP_DIV = 4'd3,
      OP_AND = 4'd4,
      OP_OR  = 4'd5,
      OP_XOR = 4'd6,
      OP_NOT = 4'd7,
      OP_SHL = 4'd8,
      OP_SHR = 4'd9
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } alu_state_e;

   function automatic logic is_iter(input alu_op_e op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Bit-serial shift-add multiplier and restoring divider, one bit per clock.
// Operands are taken straight from the request on start_i; done_o marks the final iteration.
module alu_iter_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  alu_op_e          op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] hi_o,
   output logic             dz_o
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mq_q, mq_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             is_div_q, is_div_d;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_trial;

   assign mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
   assign div_shift = {acc_q, mq_q[WIDTH-1]};
   assign div_trial = div_shift - {1'b0, opnd_q};

   // A zero divisor needs no special case: every trial succeeds, giving an
   // all-ones quotient while the dividend bits collect in the remainder.
   always_comb begin
      acc_d    = acc_q;
      mq_d     = mq_q;
      opnd_d   = opnd_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      is_div_d = is_div_q;
      if (start_i) begin
         acc_d    = '0;
         mq_d     = a_i;
         opnd_d   = b_i;
         cnt_d    = CW'(WIDTH);
         busy_d   = 1'b1;
         is_div_d = (op_i == OP_DIV);
      end else if (busy_q) begin
         if (is_div_q) begin
            acc_d = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], ~div_trial[WIDTH]};
         end else begin
            acc_d = mul_sum[WIDTH:1];
            mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
         end
         cnt_d  = cnt_q - CW'(1);
         busy_d = (cnt_q != CW'(1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         mq_q     <= '0;
         opnd_q   <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         is_div_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mq_q     <= mq_d;
         opnd_q   <= opnd_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         is_div_q <= is_div_d;
      end
   end

   assign done_o = busy_q && (cnt_q == CW'(1));
   assign lo_o   = mq_q;
   assign hi_o   = acc_q;
   assign dz_o   = is_div_q && (opnd_q == '0);

endmodule

// File: rtl/mcycle_alu.sv
// Multi-cycle ALU: single-cycle ops evaluated on captured operands, MUL/DIV iterated.
// state | meaning
// IDLE  | ready for a request
// BUSY  | MUL/DIV iterating in alu_iter_muldiv
// DONE  | result presented, waiting for out_ready
module mcycle_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  alu_op_e          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             half_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi,
   output logic             flag_c,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_v,
   output logic             flag_dz
);

   localparam int HW = WIDTH / 2;

   alu_state_e       state_q, state_d;
   alu_op_e          op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             half_q;

   logic             accept, md_start, md_done, md_dz;
   logic [WIDTH-1:0] md_lo, md_hi;

   logic [WIDTH:0]   alu_full;
   logic [WIDTH:0]   shr_ext;
   logic             alu_v;

   logic [WIDTH-1:0] r_lo, r_hi;
   logic             r_c, r_z, r_n, r_v, r_dz;

   assign accept   = in_ready && in_valid;
   assign md_start = accept && is_iter(op);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (in_valid)  state_d = is_iter(op) ? ST_BUSY : ST_DONE;
         ST_BUSY: if (md_done)   state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= OP_ADD;
         a_q    <= '0;
         b_q    <= '0;
         half_q <= 1'b0;
      end else if (accept) begin
         op_q   <= op;
         a_q    <= a;
         b_q    <= b;
         half_q <= half_mode;
      end
   end

   alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (md_start),
      .op_i    (op),
      .a_i     (a),
      .b_i     (b),
      .done_o  (md_done),
      .lo_o    (md_lo),
      .hi_o    (md_hi),
      .dz_o    (md_dz)
   );

   // Bit WIDTH of alu_full carries the carry/borrow or the last bit shifted out.
   assign shr_ext = {a_q, 1'b0} >> b_q[SHW-1:0];

   always_comb begin
      alu_full = '0;
      alu_v    = 1'b0;
      unique case (op_q)
         OP_ADD: begin
            alu_full = {1'b0, a_q} + {1'b0, b_q};
            alu_v    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_full[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SUB: begin
            alu_full = {1'b0, a_q} - {1'b0, b_q};
            alu_v    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_full[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_AND:  alu_full = {1'b0, a_q & b_q};
         OP_OR:   alu_full = {1'b0, a_q | b_q};
         OP_XOR:  alu_full = {1'b0, a_q ^ b_q};
         OP_NOT:  alu_full = {1'b0, ~a_q};
         OP_SHL:  alu_full = {1'b0, a_q} << b_q[SHW-1:0];
         OP_SHR:  alu_full = {shr_ext[0], shr_ext[WIDTH:1]};
         default: alu_full = '0;
      endcase
   end

   always_comb begin
      r_lo = '0;
      r_hi = '0;
      r_c  = 1'b0;
      r_n  = 1'b0;
      r_v  = 1'b0;
      r_dz = 1'b0;
      if (is_iter(op_q)) begin
         r_lo = md_lo;
         r_hi = md_hi;
         r_c  = (op_q == OP_MUL) && (md_hi != '0);
         r_n  = md_lo[WIDTH-1];
         r_dz = (op_q == OP_DIV) && md_dz;
      end else if (half_q) begin
         r_lo = {{(WIDTH-HW){1'b0}}, alu_full[HW-1:0]};
         r_c  = |alu_full[WIDTH:HW];
         r_n  = alu_full[HW-1];
         r_v  = alu_v;
      end else begin
         r_lo = alu_full[WIDTH-1:0];
         r_c  = alu_full[WIDTH];
         r_n  = alu_full[WIDTH-1];
         r_v  = alu_v;
      end
      r_z = (r_lo == '0);
   end

   // Results are only driven while presented, so reset and idle read as zero.
   assign res_lo  = out_valid ? r_lo : '0;
   assign res_hi  = out_valid ? r_hi : '0;
   assign flag_c  = out_valid && r_c;
   assign flag_z  = out_valid && r_z;
   assign flag_n  = out_valid && r_n;
   assign flag_v  = out_valid && r_v;
   assign flag_dz = out_valid && r_dz;

endmodule

// File: tb/tb_mcycle_alu.sv
// Self-checking bench for mcycle_alu (WIDTH=16): directed corner vectors,
// randomized ops against an arithmetic reference model, stall and reset abort.
module tb_mcycle_alu;
   import alu_pkg::*;

   localparam int W       = 16;
   localparam int MAX_LAT = 40;

   typedef struct packed {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         c;
      logic         z;
      logic         n;
      logic         v;
      logic         dz;
   } res_t;

   typedef struct packed {
      alu_op_e      op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         half;
      res_t         exp;
      logic [5:0]   lat;
   } vec_t;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         in_valid  = 1'b0;
   logic         in_ready;
   alu_op_e      op        = OP_ADD;
   logic [W-1:0] a         = '0;
   logic [W-1:0] b         = '0;
   logic         half_mode = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] res_lo, res_hi;
   logic         flag_c, flag_z, flag_n, flag_v, flag_dz;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   mcycle_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .half_mode (half_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res_lo    (res_lo),
      .res_hi    (res_hi),
      .flag_c    (flag_c),
      .flag_z    (flag_z),
      .flag_n    (flag_n),
      .flag_v    (flag_v),
      .flag_dz   (flag_dz)
   );

   function automatic res_t observe();
      return {res_lo, res_hi, flag_c, flag_z, flag_n, flag_v, flag_dz};
   endfunction

   // Reference: plain integer arithmetic on the operands.
   function automatic res_t model(input alu_op_e o, input logic [W-1:0] x,
                                  input logic [W-1:0] y, input logic hm);
      res_t   r;
      longint xl, yl, full, prod;
      int     sh, ss;
      r    = '0;
      xl   = longint'(x);
      yl   = longint'(y);
      sh   = int'(y) % W;
      full = 0;
      ss   = 0;
      case (o)
         OP_ADD: begin
            full = xl + yl;
            ss   = int'($signed(x)) + int'($signed(y));
            r.v  = (ss > 32767) || (ss < -32768);
         end
         OP_SUB: begin
            full = (xl - yl) & 64'h1FFFF;
            ss   = int'($signed(x)) - int'($signed(y));
            r.v  = (ss > 32767) || (ss < -32768);
         end
         OP_AND: full = xl & yl;
         OP_OR:  full = xl | yl;
         OP_XOR: full = xl ^ yl;
         OP_NOT: full = (~xl) & 64'hFFFF;
         OP_SHL: begin
            full = (xl << sh) & 64'hFFFF;
            if (sh != 0) full = full | (((xl >> (W - sh)) & 1) << W);
         end
         OP_SHR: begin
            full = xl >> sh;
            if (sh != 0) full = full | (((xl >> (sh - 1)) & 1) << W);
         end
         OP_MUL: begin
            prod = xl * yl;
            r.lo = 16'(prod);
            r.hi = 16'(prod >> W);
            r.c  = (r.hi != 0);
            r.n  = r.lo[W-1];
            r.z  = (r.lo == 0);
            return r;
         end
         OP_DIV: begin
            if (y == 0) begin
               r.lo = 16'hFFFF;
               r.hi = x;
               r.dz = 1'b1;
            end else begin
               r.lo = 16'(xl / yl);
               r.hi = 16'(xl % yl);
            end
            r.n = r.lo[W-1];
            r.z = (r.lo == 0);
            return r;
         end
         default: full = 0;
      endcase
      if (hm) begin
         r.lo = 16'(full & 64'hFF);
         r.c  = ((full >> (W/2)) != 0);
         r.n  = r.lo[W/2-1];
      end else begin
         r.lo = 16'(full);
         r.c  = (((full >> W) & 1) != 0);
         r.n  = r.lo[W-1];
      end
      r.z = (r.lo == 0);
      return r;
   endfunction

   function automatic vec_t mk(input alu_op_e o, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic hm, input logic [W-1:0] lo, input logic [W-1:0] hi,
                               input logic [4:0] czn_v_dz, input int lat);
      vec_t v;
      v.op   = o;
      v.a    = x;
      v.b    = y;
      v.half = hm;
      v.exp  = {lo, hi, czn_v_dz};
      v.lat  = 6'(lat);
      return v;
   endfunction

   // Present one request, scramble inputs while busy, wait for the result, consume it.
   task automatic do_op(input alu_op_e o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic hm, output res_t got, output int lat);
      @(negedge clk);
      op = o; a = x; b = y; half_mode = hm; in_valid = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!out_valid) begin
            in_valid  = 1'($urandom_range(0, 1));
            op        = alu_op_e'(4'($urandom_range(0, 9)));
            a         = W'($urandom);
            b         = W'($urandom);
            half_mode = 1'($urandom_range(0, 1));
         end
      end while (!out_valid && lat < MAX_LAT);
      in_valid  = 1'b0;
      got       = observe();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
      else pass_cnt++;
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
      else pass_cnt++;
      total_cnt++;
      if ({res_lo, res_hi} !== 32'h0) $display("FAIL reset_results: got %h want 0", {res_lo, res_hi});
      else pass_cnt++;
      total_cnt++;
      if ({flag_c, flag_z, flag_n, flag_v, flag_dz} !== 5'b0)
         $display("FAIL reset_flags: got %b want 00000", {flag_c, flag_z, flag_n, flag_v, flag_dz});
      else pass_cnt++;
      rst_n = 1'b1;
   endtask

   task automatic test_spec_vectors();
      vec_t vecs[15];
      res_t got;
      int   lat;
      //              op      a         b         h  lo        hi        cznv dz   lat
      vecs[0]  = mk(OP_ADD, 16'hFFFF, 16'h0001, 0, 16'h0000, 16'h0000, 5'b11000, 1);
      vecs[1]  = mk(OP_MUL, 16'h1234, 16'h0100, 0, 16'h3400, 16'h0012, 5'b10000, 17);
      vecs[2]  = mk(OP_DIV, 16'd100,  16'd7,    0, 16'd14,   16'd2,    5'b00000, 17);
      vecs[3]  = mk(OP_DIV, 16'h00AB, 16'h0000, 0, 16'hFFFF, 16'h00AB, 5'b00101, 17);
      vecs[4]  = mk(OP_ADD, 16'h00F0, 16'h0020, 1, 16'h0010, 16'h0000, 5'b10000, 1);
      vecs[5]  = mk(OP_SUB, 16'h7FFF, 16'hFFFF, 0, 16'h8000, 16'h0000, 5'b10110, 1);
      vecs[6]  = mk(OP_SHL, 16'h8001, 16'h0000, 0, 16'h8001, 16'h0000, 5'b00100, 1);
      vecs[7]  = mk(OP_SHL, 16'h8001, 16'h0001, 0, 16'h0002, 16'h0000, 5'b10000, 1);
      vecs[8]  = mk(OP_SHR, 16'h8000, 16'h000F, 0, 16'h0001, 16'h0000, 5'b00000, 1);
      vecs[9]  = mk(OP_NOT, 16'hFFFF, 16'h5A5A, 0, 16'h0000, 16'h0000, 5'b01000, 1);
      vecs[10] = mk(OP_XOR, 16'h1234, 16'h0034, 1, 16'h0000, 16'h0000, 5'b11000, 1);
      vecs[11] = mk(OP_MUL, 16'hFFFF, 16'hFFFF, 0, 16'h0001, 16'hFFFE, 5'b10000, 17);
      vecs[12] = mk(OP_SUB, 16'h0000, 16'h0001, 0, 16'hFFFF, 16'h0000, 5'b10100, 1);
      vecs[13] = mk(OP_SHL, 16'h0001, 16'h0011, 0, 16'h0002, 16'h0000, 5'b00000, 1);
      vecs[14] = mk(OP_SHR, 16'h0003, 16'h0001, 0, 16'h0001, 16'h0000, 5'b10000, 1);
      for (int i = 0; i < 15; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].half, got, lat);
         total_cnt++;
         if (got !== vecs[i].exp)
            $display("FAIL vec%0d_result: got %h want %h", i, got, vecs[i].exp);
         else pass_cnt++;
         total_cnt++;
         if (lat !== int'(vecs[i].lat))
            $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, vecs[i].lat);
         else pass_cnt++;
      end
   endtask

   task automatic test_random();
      res_t         got, exp;
      int           lat, exp_lat;
      alu_op_e      o;
      logic [W-1:0] x, y;
      logic         hm;
      for (int i = 0; i < 60; i++) begin
         o  = alu_op_e'(4'($urandom_range(0, 9)));
         x  = W'($urandom);
         y  = W'($urandom);
         hm = 1'($urandom_range(0, 1));
         if (o == OP_DIV && $urandom_range(0, 7) == 0) y = '0;
         exp     = model(o, x, y, hm);
         exp_lat = (o == OP_MUL || o == OP_DIV) ? W + 1 : 1;
         do_op(o, x, y, hm, got, lat);
         total_cnt++;
         if (got !== exp)
            $display("FAIL rand%0d_result op=%0d a=%h b=%h h=%b: got %h want %h",
                     i, o, x, y, hm, got, exp);
         else pass_cnt++;
         total_cnt++;
         if (lat !== exp_lat) $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, exp_lat);
         else pass_cnt++;
         total_cnt++;
         if (in_ready !== 1'b1) $display("FAIL rand%0d_idle_after: in_ready got %b want 1", i, in_ready);
         else pass_cnt++;
      end
   endtask

   task automatic test_stall();
      res_t         held, exp;
      int           n;
      alu_op_e      o;
      logic [W-1:0] x, y;
      logic         hm;
      for (int k = 0; k < 2; k++) begin
         o  = (k == 0) ? OP_DIV : OP_ADD;
         x  = W'($urandom);
         y  = W'($urandom_range(1, 300));
         hm = 1'(k);
         exp = model(o, x, y, hm);
         @(negedge clk);
         op = o; a = x; b = y; half_mode = hm; in_valid = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         n = 1;
         while (!out_valid && n < MAX_LAT) begin
            @(negedge clk);
            n++;
         end
         total_cnt++;
         if (out_valid !== 1'b1) $display("FAIL stall%0d_timeout: out_valid got %b want 1", k, out_valid);
         else pass_cnt++;
         held = observe();
         total_cnt++;
         if (held !== exp) $display("FAIL stall%0d_result: got %h want %h", k, held, exp);
         else pass_cnt++;
         for (int c = 0; c < 5; c++) begin
            in_valid  = 1'b1;
            op        = alu_op_e'(4'($urandom_range(0, 9)));
            a         = W'($urandom);
            b         = W'($urandom);
            half_mode = 1'($urandom_range(0, 1));
            out_ready = 1'b0;
            @(negedge clk);
            total_cnt++;
            if ({out_valid, in_ready, observe()} !== {1'b1, 1'b0, held})
               $display("FAIL stall%0d_hold%0d: got v=%b r=%b %h want v=1 r=0 %h",
                        k, c, out_valid, in_ready, observe(), held);
            else pass_cnt++;
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         total_cnt++;
         if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL stall%0d_release: got v=%b r=%b want v=0 r=1", k, out_valid, in_ready);
         else pass_cnt++;
         @(negedge clk);
         total_cnt++;
         if (out_valid !== 1'b0) $display("FAIL stall%0d_no_phantom: out_valid got %b want 0", k, out_valid);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_busy();
      res_t exp;
      logic seen;
      @(negedge clk);
      op = OP_MUL; a = 16'h1234; b = 16'h0100; half_mode = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      total_cnt++;
      if ({out_valid, in_ready} !== 2'b00)
         $display("FAIL abort_busy_before: got v=%b r=%b want v=0 r=0", out_valid, in_ready);
      else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({out_valid, in_ready} !== 2'b01)
         $display("FAIL abort_async_handshake: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
      else pass_cnt++;
      total_cnt++;
      if (observe() !== res_t'(0)) $display("FAIL abort_async_outputs: got %h want 0", observe());
      else pass_cnt++;
      @(negedge clk);
      exp = model(OP_ADD, 16'd3, 16'd4, 1'b0);
      rst_n = 1'b1;
      op = OP_ADD; a = 16'd3; b = 16'd4; half_mode = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      total_cnt++;
      if ({out_valid, observe()} !== {1'b1, exp})
         $display("FAIL abort_first_request: got v=%b %h want v=1 %h", out_valid, observe(), exp);
      else pass_cnt++;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      total_cnt++;
      if (seen !== 1'b0) $display("FAIL abort_stale_result: out_valid seen %b want 0", seen);
      else pass_cnt++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_spec_vectors();
      test_random();
      test_stall();
      test_reset_busy();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mcycle_alu.md
MCYCLE_ALU -- requirements
Module: mcycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (even, >=8).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  single clock, rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports in_valid input 1 (request valid) and in_ready output 1 (request accepted when both high).
REQ-006 SHALL have ports op input alu_op_e, a input WIDTH, b input WIDTH, half_mode input 1 (captured at acceptance).
REQ-007 SHALL have ports out_valid output 1 (result valid) and out_ready input 1 (result consumed when both high).
REQ-008 SHALL have ports res_lo output WIDTH (primary result) and res_hi output WIDTH (MUL high half / DIV remainder, else 0).
REQ-009 SHALL have ports flag_c, flag_z, flag_n, flag_v, flag_dz, each output 1 (carry, zero, negative, signed overflow, divide-by-zero).

Function
REQ-010 SHALL implement ops ADD, SUB, MUL, DIV, AND, OR, XOR, NOT, SHL, SHR, all unsigned except flag_v.
REQ-011 SHALL use FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-012 SHALL register operands, op and half_mode on acceptance; inputs ignored outside IDLE.
REQ-013 SHALL take single-cycle ops IDLE->DONE: out_valid asserts the cycle after acceptance.
REQ-014 SHALL take MUL/DIV IDLE->BUSY, iterate exactly WIDTH cycles (shift-add / restoring divide, one bit per cycle), then BUSY->DONE: out_valid asserts WIDTH+1 cycles after acceptance.
REQ-015 SHALL hold res_lo, res_hi and all flags stable in DONE until out_ready=1; DONE->IDLE on out_ready.
REQ-016 SHALL compute ADD/SUB in WIDTH+1 bits; flag_c = bit WIDTH (borrow for SUB); flag_v = signed overflow of the WIDTH-bit result.
REQ-017 SHALL shift SHL/SHR by b[SHW-1:0], zero fill; flag_c = last bit shifted out (0 for shift by 0).
REQ-018 SHALL produce MUL full 2*WIDTH product as {res_hi,res_lo}; flag_c=1 when res_hi!=0.
REQ-019 SHALL produce DIV quotient in res_lo, remainder in res_hi; for b=0: res_lo=all ones, res_hi=a, flag_dz=1, still WIDTH+1 latency.
REQ-020 SHALL, in half_mode, zero-extend the low WIDTH/2 bits into res_lo; flag_c = OR of bits [WIDTH:WIDTH/2] of the internal sum (ADD/SUB/logic/shift); flag_z, flag_n evaluated on the low half; MUL/DIV ignore half_mode.
REQ-021 SHALL set flag_z when res_lo==0 (res_hi ignored), flag_n = MSB of the effective result.
REQ-022 SHALL clear flag_v for non-ADD/SUB ops and flag_dz for non-DIV ops.

Reset
REQ-023 SHALL, on rst_n low at any time including BUSY, go to IDLE asynchronously with in_ready=1, out_valid=0, res_lo=0, res_hi=0, all flags 0; aborted operation produces no result.
REQ-024 SHALL accept a new request on the first rising clk edge after rst_n deasserts.

Structure
REQ-025 SHALL take alu_op_e (4-bit enum) and the FSM state typedef from shared package alu_pkg.
REQ-026 SHALL place the iterative multiply/divide datapath (iteration counter, partial product/remainder registers) in sub-module alu_iter_muldiv with start/done strobes.
REQ-027 SHALL keep single-cycle ops combinational on registered operands inside mcycle_alu.

Verification (WIDTH=16)
REQ-028 ADD a=0xFFFF b=0x0001 -> next cycle out_valid, res_lo=0x0000, c=1, z=1, v=0.
REQ-029 MUL a=0x1234 b=0x0100 -> out_valid at cycle 17, res_lo=0x3400, res_hi=0x0012, c=1.
REQ-030 DIV 100/7 -> res_lo=14, res_hi=2, dz=0; DIV 0x00AB/0 -> res_lo=0xFFFF, res_hi=0x00AB, dz=1.
REQ-031 half_mode ADD 0x00F0+0x0020 -> res_lo=0x0010, c=1, z=0; SUB 0x7FFF-0xFFFF full mode -> res_lo=0x8000, v=1.
REQ-032 out_ready low 5 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored; then one handshake, IDLE.
REQ-033 rst_n low at BUSY cycle 8 of MUL -> out_valid=0, in_ready=1 immediately; no stale result after release.
